// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected inference chain.
// Holds the loader FSM states and the pixel to Q8.8 conversion.
package fc_pkg;

  localparam int unsigned FC_IN_NEURONS = 784;
  localparam int unsigned FC_DATA_W     = 16;
  localparam int unsigned FC_PIX_W      = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2
  } fc_state_e;

  // Zero-extend an unsigned pixel, shift it into Q8.8 and truncate to the word width.
  function automatic logic [FC_DATA_W-1:0] pix_to_q88(input logic [FC_PIX_W-1:0] pixel,
                                                      input int unsigned shift);
    logic [FC_DATA_W-1:0] ext;
    ext = {{(FC_DATA_W-FC_PIX_W){1'b0}}, pixel};
    return ext << shift;
  endfunction

endpackage

// File: rtl/fc_frame_loader.sv
// Front-end feeder for the fully-connected chain: packs one frame of pixels into the
// flat Q8.8 input vector, then clears, starts and waits on the chain.
module fc_frame_loader
  import fc_pkg::*;
#(
  parameter int unsigned IN_NEURONS = FC_IN_NEURONS,
  parameter int unsigned DATA_W     = FC_DATA_W,
  parameter int unsigned PIX_W      = FC_PIX_W,
  parameter int unsigned PIX_SHIFT  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [PIX_W-1:0]             s_data,
  input  logic                         s_last,
  output logic                         net_rst,
  output logic                         net_start,
  output logic [IN_NEURONS*DATA_W-1:0] net_in_data,
  input  logic                         net_done,
  output logic                         result_valid,
  output logic [7:0]                   frame_id,
  output logic                         err_len
);

  localparam int unsigned CNT_W = (IN_NEURONS > 1) ? $clog2(IN_NEURONS) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(IN_NEURONS - 1);

  fc_state_e state_q, state_d;

  logic [CNT_W-1:0]             pix_cnt_q, pix_cnt_d;
  logic [IN_NEURONS*DATA_W-1:0] vec_q, vec_d;
  logic                         s_ready_q, s_ready_d;
  logic                         net_rst_q, net_rst_d;
  logic                         net_start_q, net_start_d;
  logic                         result_valid_q, result_valid_d;
  logic [7:0]                   frame_id_q, frame_id_d;
  logic                         err_len_q, err_len_d;

  logic accept;
  logic at_last_slot;
  logic frame_end;
  logic chain_done;

  // s_ready_q is only high in LOAD, so accept implies LOAD.
  assign accept       = s_valid && s_ready_q;
  assign at_last_slot = (pix_cnt_q == LAST_SLOT);
  assign frame_end    = accept && (s_last || at_last_slot);
  assign chain_done   = (state_q == RUN) && net_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (frame_end) state_d = CLR;
      CLR:     state_d = RUN;
      RUN:     if (net_done) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    pix_cnt_d      = pix_cnt_q;
    vec_d          = vec_q;
    frame_id_d     = frame_id_q;
    err_len_d      = err_len_q;
    s_ready_d      = (state_d == LOAD);
    net_rst_d      = (state_d == CLR);
    net_start_d    = (state_d == RUN);
    result_valid_d = chain_done;

    if (accept) begin
      vec_d[pix_cnt_q*DATA_W +: DATA_W] = DATA_W'(pix_to_q88(s_data, PIX_SHIFT));
      pix_cnt_d = pix_cnt_q + 1'b1;
    end
    if (frame_end) begin
      // Next frame starts at slot 0 even when this one closed without s_last.
      pix_cnt_d = '0;
      err_len_d = (s_last != at_last_slot);
    end
    if (chain_done) begin
      vec_d      = '0;
      pix_cnt_d  = '0;
      frame_id_d = frame_id_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_q      <= '0;
      vec_q          <= '0;
      s_ready_q      <= 1'b1;
      net_rst_q      <= 1'b0;
      net_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
      frame_id_q     <= 8'd0;
      err_len_q      <= 1'b0;
    end else begin
      pix_cnt_q      <= pix_cnt_d;
      vec_q          <= vec_d;
      s_ready_q      <= s_ready_d;
      net_rst_q      <= net_rst_d;
      net_start_q    <= net_start_d;
      result_valid_q <= result_valid_d;
      frame_id_q     <= frame_id_d;
      err_len_q      <= err_len_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign net_rst      = net_rst_q;
  assign net_start    = net_start_q;
  assign net_in_data  = vec_q;
  assign result_valid = result_valid_q;
  assign frame_id     = frame_id_q;
  assign err_len      = err_len_q;

endmodule

// File: tb/tb_fc_frame_loader.sv
// Scoreboard bench for fc_frame_loader: the driver pushes the expected vector per frame,
// a monitor pops and checks it when the loader starts the chain.
module tb_fc_frame_loader;

  localparam int unsigned N  = 784;
  localparam int unsigned DW = 16;
  localparam int unsigned PW = 8;

  typedef struct {
    logic [N*DW-1:0] vec;
    logic            err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [PW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          net_rst;
  logic          net_start;
  logic [N*DW-1:0] net_in_data;
  logic          net_done = 1'b0;
  logic          result_valid;
  logic [7:0]    frame_id;
  logic          err_len;

  // Small instance for the shifted conversion
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [PW-1:0] b_data = '0;
  logic          b_last = 1'b0;
  logic          b_net_rst;
  logic          b_net_start;
  logic [4*DW-1:0] b_in_data;
  logic          b_done = 1'b0;
  logic          b_result_valid;
  logic [7:0]    b_frame_id;
  logic          b_err_len;

  int checks = 0;
  int failures = 0;
  int frames_pushed = 0;
  int frames_done = 0;

  exp_t            sb[$];
  logic [N*DW-1:0] model_vec;
  int              model_cnt;

  always #5 clk = ~clk;

  fc_frame_loader #(.IN_NEURONS(N), .DATA_W(DW), .PIX_W(PW), .PIX_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .net_rst(net_rst), .net_start(net_start), .net_in_data(net_in_data),
    .net_done(net_done), .result_valid(result_valid), .frame_id(frame_id), .err_len(err_len)
  );

  fc_frame_loader #(.IN_NEURONS(4), .DATA_W(DW), .PIX_W(PW), .PIX_SHIFT(4)) dut_sh (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .s_last(b_last), .net_rst(b_net_rst), .net_start(b_net_start), .net_in_data(b_in_data),
    .net_done(b_done), .result_valid(b_result_valid), .frame_id(b_frame_id),
    .err_len(b_err_len)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Chain stub: done 50 cycles after start, sticky until the clear pulse.
  int run_cnt = 0;
  always @(negedge clk) begin
    if (rst || net_rst) begin
      net_done = 1'b0;
      run_cnt  = 0;
    end else if (net_start) begin
      run_cnt++;
      if (run_cnt == 50) net_done = 1'b1;
    end
  end

  // Monitor
  logic       prev_start = 1'b0;
  logic       prev_rst = 1'b0;
  logic [7:0] fid_exp = 8'd0;
  always @(negedge clk) begin
    if (rst) begin
      fid_exp    = 8'd0;
      prev_start = 1'b0;
      prev_rst   = 1'b0;
    end else begin
      if (net_start && !prev_start) begin
        check("clr_before_start", 64'(prev_rst), 64'd1);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: got start expected no frame");
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          if (net_in_data !== e.vec) begin
            failures++;
            for (int k = 0; k < int'(N); k++)
              if (net_in_data[k*DW +: DW] !== e.vec[k*DW +: DW]) begin
                $display("FAIL vector_slot%0d: got 0x%0h expected 0x%0h", k,
                         net_in_data[k*DW +: DW], e.vec[k*DW +: DW]);
                break;
              end
          end
          check("err_len", 64'(err_len), 64'(e.err));
        end
      end
      if (net_rst && prev_rst) check("net_rst_width", 64'd2, 64'd1);
      if (net_rst || net_start) check("s_ready_busy", 64'(s_ready), 64'd0);
      if (result_valid) begin
        check("frame_id", 64'(frame_id), 64'(fid_exp + 8'd1));
        check("start_dropped", 64'(net_start), 64'd0);
        check("s_ready_back", 64'(s_ready), 64'd1);
        fid_exp = fid_exp + 8'd1;
        frames_done++;
      end
      prev_start = net_start;
      prev_rst   = net_rst;
    end
  end

  task automatic model_reset();
    model_vec = '0;
    model_cnt = 0;
  endtask

  // Present one beat from a negedge; returns at the negedge after it is accepted.
  task automatic send_beat(input logic [PW-1:0] d, input logic last);
    int wait_cyc;
    s_valid  = 1'b1;
    s_data   = d;
    s_last   = last;
    wait_cyc = 0;
    while (!s_ready && wait_cyc < 2000) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got s_ready=0 expected 1");
      s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    model_vec[model_cnt*DW +: DW] = {8'h00, d};
    if (last || model_cnt == int'(N) - 1) begin
      sb.push_back('{vec: model_vec, err: (last != (model_cnt == int'(N) - 1))});
      frames_pushed++;
      model_reset();
    end else begin
      model_cnt++;
    end
  endtask

  task automatic send_run(input int count, input int last_at, input int fixed_val,
                          input bit gaps);
    for (int k = 0; k < count; k++) begin
      logic [PW-1:0] d;
      d = (fixed_val >= 0) ? PW'(fixed_val) : PW'(k & 8'hFF);
      send_beat(d, k == last_at);
      if (gaps && $urandom_range(1, 0) == 1) begin
        s_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((frames_done < frames_pushed || net_start || net_rst) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_reached", 64'(frames_done), 64'(frames_pushed));
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_net_start", 64'(net_start), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_frame_id", 64'(frame_id), 64'd0);
    check("reset_vec_zero", 64'(net_in_data == '0), 64'd1);

    send_run(784, 783, -1, 1'b0);       // full frame, ramp pattern
    wait_idle();
    send_run(10, 9, 8'hFF, 1'b0);       // early s_last
    wait_idle();
    send_run(790, 789, -1, 1'b0);       // missing s_last, spill into second frame
    wait_idle();
    send_run(784, 783, -1, 1'b1);       // random gaps, source held through CLR/RUN
    wait_idle();

    send_run(400, -1, -1, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_s_ready", 64'(s_ready), 64'd1);
    check("midrst_vec", 64'(net_in_data == '0), 64'd1);
    check("midrst_frame_id", 64'(frame_id), 64'd0);
    check("midrst_err_len", 64'(err_len), 64'd0);
    check("midrst_ctl", 64'({net_rst, net_start, result_valid}), 64'd0);
    model_reset();
    frames_done   = 0;
    frames_pushed = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_run(784, 783, -1, 1'b0);
    wait_idle();
    check("post_rst_frame_id", 64'(frame_id), 64'd1);

    // Shifted conversion on a 4-slot instance
    for (int k = 0; k < 4; k++) begin
      b_valid = 1'b1;
      b_data  = (k == 1) ? 8'h0F : 8'h80;
      b_last  = (k == 3);
      @(negedge clk);
    end
    b_valid = 1'b0;
    b_last  = 1'b0;
    for (int c = 0; c < 20 && !b_net_start; c++) @(negedge clk);
    check("sh_started", 64'(b_net_start), 64'd1);
    check("sh_slot0", 64'(b_in_data[0 +: DW]), 64'h0800);
    check("sh_slot1", 64'(b_in_data[DW +: DW]), 64'h00F0);
    check("sh_slot3", 64'(b_in_data[3*DW +: DW]), 64'h0800);
    check("sh_err_len", 64'(b_err_len), 64'd0);
    b_done = 1'b1;
    @(negedge clk);
    check("sh_result_valid", 64'(b_result_valid), 64'd1);
    check("sh_frame_id", 64'(b_frame_id), 64'd1);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
